// File: rtl/mips_run_controller.sv
// mips_run_controller: run/supervision controller for the 32-bit MIPS core.
// It holds the core in reset for RST_CYCLES after a start pulse, then enables
// it and counts RUN cycles. A run ends on the halt instruction word, a PC that
// stays unchanged for STALL_LIMIT cycles, or the MAX_CYCLES budget running out.
// abort returns the controller to IDLE from any state.
// Optional feature macro: MIPS_RUN_CTRL_PC_TRACE_EN (8-entry PC trace buffer).
`timescale 1ns/1ps

module mips_run_controller #(
   parameter int                 PC_W        = 32,
   parameter int                 INSTR_W     = 32,
   parameter int                 CNT_W       = 16,
   parameter int                 RST_CYCLES  = 4,
   parameter int                 MAX_CYCLES  = 25,
   parameter int                 STALL_LIMIT = 3,
   parameter logic [INSTR_W-1:0] HALT_INSTR  = 32'hFC00_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr,
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
   input  logic [2:0]         trace_idx,
   output logic [PC_W-1:0]    trace_pc,
`endif
   output logic               core_rst,
   output logic               core_en,
   output logic               running,
   output logic               done,
   output logic [1:0]         halt_reason,
   output logic [CNT_W-1:0]   cycle_count
);

   // Counter widths; a reset-length counter counts 0 .. RST_CYCLES-1.
   localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

   localparam logic [1:0] REASON_NONE  = 2'b00;
   localparam logic [1:0] REASON_HALT  = 2'b01;
   localparam logic [1:0] REASON_STALL = 2'b10;
   localparam logic [1:0] REASON_TOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [RST_W-1:0]   rst_cnt_r, rst_cnt_nxt_s;
   logic [STALL_W-1:0] stall_r, stall_nxt_s, stall_inc_s;
   logic [PC_W-1:0]    prev_pc_r, prev_pc_nxt_s;
   logic [CNT_W-1:0]   cycle_count_r, cycle_nxt_s, cnt_inc_s;
   logic [1:0]         reason_r, reason_nxt_s;
   logic               core_rst_r, core_rst_nxt_s;
   logic               core_en_r, core_en_nxt_s;
   logic               running_r, running_nxt_s;
   logic               done_r, done_nxt_s;
   logic               same_pc_s;

   // Run-cycle increment and stall detection; the PC comparison is skipped on
   // the first RUN cycle (cycle_count still 0) because prev_pc is stale there.
   always_comb begin
      cnt_inc_s = cycle_count_r + CNT_W'(1);
      same_pc_s = (cycle_count_r != CNT_W'(0)) && (pc == prev_pc_r);
      if (same_pc_s) begin
         stall_inc_s = stall_r + STALL_W'(1);
      end else begin
         stall_inc_s = STALL_W'(0);
      end
   end

   // Next-state and next-value logic for the sequencing FSM and its counters.
   always_comb begin
      state_nxt_s   = state_r;
      rst_cnt_nxt_s = rst_cnt_r;
      stall_nxt_s   = stall_r;
      prev_pc_nxt_s = prev_pc_r;
      cycle_nxt_s   = cycle_count_r;
      reason_nxt_s  = reason_r;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start && !abort) begin
               state_nxt_s   = ST_RESET;
               rst_cnt_nxt_s = RST_W'(0);
               stall_nxt_s   = STALL_W'(0);
               cycle_nxt_s   = CNT_W'(0);
               reason_nxt_s  = REASON_NONE;
            end else begin
               state_nxt_s   = state_r;
            end
         end
         ST_RESET: begin
            if (rst_cnt_r == RST_W'(RST_CYCLES - 1)) begin
               state_nxt_s   = ST_RUN;
            end else begin
               rst_cnt_nxt_s = rst_cnt_r + RST_W'(1);
            end
         end
         ST_RUN: begin
            // The terminating cycle is counted as well.
            cycle_nxt_s   = cnt_inc_s;
            stall_nxt_s   = stall_inc_s;
            prev_pc_nxt_s = pc;
            if (instr == HALT_INSTR) begin
               state_nxt_s  = ST_DONE;
               reason_nxt_s = REASON_HALT;
            end else if (stall_inc_s == STALL_W'(STALL_LIMIT)) begin
               state_nxt_s  = ST_DONE;
               reason_nxt_s = REASON_STALL;
            end else if (cnt_inc_s == CNT_W'(MAX_CYCLES)) begin
               state_nxt_s  = ST_DONE;
               reason_nxt_s = REASON_TOUT;
            end else begin
               state_nxt_s  = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      // abort wins over start and every halt condition; the cycle count keeps
      // whatever value the current cycle produced.
      if (abort) begin
         state_nxt_s  = ST_IDLE;
         reason_nxt_s = REASON_NONE;
      end else begin
         reason_nxt_s = reason_nxt_s;
      end
   end

   // Decode the registered control outputs from the next state so they line
   // up with the state register after each edge.
   always_comb begin
      core_rst_nxt_s = 1'b1;
      core_en_nxt_s  = 1'b0;
      running_nxt_s  = 1'b0;
      done_nxt_s     = 1'b0;
      case (state_nxt_s)
         ST_IDLE, ST_RESET: begin
            core_rst_nxt_s = 1'b1;
         end
         ST_RUN: begin
            core_rst_nxt_s = 1'b0;
            core_en_nxt_s  = 1'b1;
            running_nxt_s  = 1'b1;
         end
         ST_DONE: begin
            core_rst_nxt_s = 1'b0;
            done_nxt_s     = 1'b1;
         end
         default: begin
            core_rst_nxt_s = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs; reset is asynchronous.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         rst_cnt_r     <= RST_W'(0);
         stall_r       <= STALL_W'(0);
         prev_pc_r     <= PC_W'(0);
         cycle_count_r <= CNT_W'(0);
         reason_r      <= REASON_NONE;
         core_rst_r    <= 1'b1;
         core_en_r     <= 1'b0;
         running_r     <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         rst_cnt_r     <= rst_cnt_nxt_s;
         stall_r       <= stall_nxt_s;
         prev_pc_r     <= prev_pc_nxt_s;
         cycle_count_r <= cycle_nxt_s;
         reason_r      <= reason_nxt_s;
         core_rst_r    <= core_rst_nxt_s;
         core_en_r     <= core_en_nxt_s;
         running_r     <= running_nxt_s;
         done_r        <= done_nxt_s;
      end
   end

   assign core_rst    = core_rst_r;
   assign core_en     = core_en_r;
   assign running     = running_r;
   assign done        = done_r;
   assign halt_reason = reason_r;
   assign cycle_count = cycle_count_r;

`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
   logic [PC_W-1:0] trace_buf_r [8];
   logic [2:0]      trace_wp_r;
   logic [2:0]      trace_rd_s;
   logic            trace_clr_s;
   logic            trace_wr_s;

   // Trace control: clear on launch of a new run, capture on every RUN cycle.
   always_comb begin
      trace_clr_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !abort;
      trace_wr_s  = (state_r == ST_RUN);
   end

   // Ring buffer of recent PCs; the write pointer wraps 7 -> 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trace_wp_r <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            trace_buf_r[i] <= PC_W'(0);
         end
      end else if (trace_clr_s) begin
         trace_wp_r <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            trace_buf_r[i] <= PC_W'(0);
         end
      end else if (trace_wr_s) begin
         trace_buf_r[trace_wp_r] <= pc;
         trace_wp_r              <= trace_wp_r + 3'd1;
      end else begin
         trace_wp_r <= trace_wp_r;
      end
   end

   // Combinational read; index 0 is the most recently written entry.
   always_comb begin
      trace_rd_s = trace_wp_r - 3'd1 - trace_idx;
      trace_pc   = trace_buf_r[trace_rd_s];
   end
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed self-checking bench for mips_run_controller. Two instances share
// the stimulus: dut1 with default parameters, dut2 with MAX_CYCLES=10 for the
// halt/timeout collision case.
`timescale 1ns/1ps

module tb_mips_run_controller;

   localparam logic [31:0] HALT = 32'hFC00_0000;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] pc;
   logic [31:0] instr;

   logic        core_rst1, core_en1, running1, done1;
   logic [1:0]  reason1;
   logic [15:0] count1;
   logic        core_rst2, core_en2, running2, done2;
   logic [1:0]  reason2;
   logic [15:0] count2;
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
   logic [2:0]  trace_idx;
   logic [31:0] trace_pc1;
   logic [31:0] trace_pc2;
`endif

   int n_cmp = 0;
   int n_err = 0;

   mips_run_controller dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .instr(instr),
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
      .trace_idx(trace_idx), .trace_pc(trace_pc1),
`endif
      .core_rst(core_rst1), .core_en(core_en1), .running(running1), .done(done1),
      .halt_reason(reason1), .cycle_count(count1)
   );

   mips_run_controller #(.MAX_CYCLES(10)) dut2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc), .instr(instr),
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
      .trace_idx(trace_idx), .trace_pc(trace_pc2),
`endif
      .core_rst(core_rst2), .core_en(core_en2), .running(running2), .done(done2),
      .halt_reason(reason2), .cycle_count(count2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start pulse plus the full reset phase; returns in the first RUN cycle
   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; pc = 32'd0; instr = 32'd0;
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
      trace_idx = 3'd0;
`endif
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({core_rst1, core_en1, running1, done1} !== 4'b1000 || reason1 !== 2'b00 || count1 !== 16'd0) begin
         n_err++;
         $display("FAIL reset_async: rst/en/run/done=%b reason=%b count=%0d, want 1000 00 0",
                  {core_rst1, core_en1, running1, done1}, reason1, count1);
      end
      repeat (3) tick();
      n_cmp++;
      if ({core_rst1, core_en1, running1, done1} !== 4'b1000 || reason1 !== 2'b00 || count1 !== 16'd0) begin
         n_err++;
         $display("FAIL reset_hold: rst/en/run/done=%b reason=%b count=%0d, want 1000 00 0",
                  {core_rst1, core_en1, running1, done1}, reason1, count1);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({core_rst1, core_en1, running1, done1} !== 4'b1000) begin
         n_err++;
         $display("FAIL idle_after_reset: rst/en/run/done=%b, want 1000", {core_rst1, core_en1, running1, done1});
      end
   endtask

   task automatic test_timeout();
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         start = 1'b0;
         n_cmp++;
         if (core_rst1 !== 1'b1 || core_en1 !== 1'b0 || running1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_phase[%0d]: core_rst=%b core_en=%b running=%b, want 1 0 0",
                     i, core_rst1, core_en1, running1);
         end
      end
      tick();
      n_cmp++;
      if (core_rst1 !== 1'b0 || core_en1 !== 1'b1 || running1 !== 1'b1) begin
         n_err++;
         $display("FAIL run_entry: core_rst=%b core_en=%b running=%b, want 0 1 1", core_rst1, core_en1, running1);
      end
      for (int n = 0; n < 25; n++) begin
         pc = 32'(4 * n);
         instr = 32'd0;
         tick();
         if (n == 23) begin
            n_cmp++;
            if (running1 !== 1'b1 || count1 !== 16'd24) begin
               n_err++;
               $display("FAIL timeout_pre: running=%b count=%0d, want 1 24", running1, count1);
            end
         end
      end
      n_cmp++;
      if (done1 !== 1'b1 || reason1 !== 2'b11 || count1 !== 16'd25 || core_en1 !== 1'b0 || core_rst1 !== 1'b0) begin
         n_err++;
         $display("FAIL timeout: done=%b reason=%b count=%0d en=%b rst=%b, want 1 11 25 0 0",
                  done1, reason1, count1, core_en1, core_rst1);
      end
      n_cmp++;
      if (done2 !== 1'b1 || reason2 !== 2'b11 || count2 !== 16'd10) begin
         n_err++;
         $display("FAIL timeout_max10: done=%b reason=%b count=%0d, want 1 11 10", done2, reason2, count2);
      end
   endtask

   task automatic test_halt_instr();
      launch();
      for (int n = 1; n <= 7; n++) begin
         pc = 32'(4 * (n - 1));
         instr = (n == 7) ? HALT : 32'h0000_0020;
         tick();
         if (n == 6) begin
            n_cmp++;
            if (core_en1 !== 1'b1 || count1 !== 16'd6) begin
               n_err++;
               $display("FAIL halt_pre: core_en=%b count=%0d, want 1 6", core_en1, count1);
            end
         end
      end
      instr = 32'd0;
      n_cmp++;
      if (done1 !== 1'b1 || reason1 !== 2'b01 || count1 !== 16'd7 || core_en1 !== 1'b0) begin
         n_err++;
         $display("FAIL halt_instr: done=%b reason=%b count=%0d en=%b, want 1 01 7 0", done1, reason1, count1, core_en1);
      end
      tick();
      n_cmp++;
      if (done1 !== 1'b1 || reason1 !== 2'b01 || count1 !== 16'd7) begin
         n_err++;
         $display("FAIL done_hold: done=%b reason=%b count=%0d, want 1 01 7", done1, reason1, count1);
      end
   endtask

   task automatic test_stall();
      logic [31:0] pcs [6];
      pcs = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
      launch();
      for (int n = 0; n < 6; n++) begin
         pc = pcs[n];
         tick();
         if (n == 4) begin
            n_cmp++;
            if (running1 !== 1'b1) begin
               n_err++;
               $display("FAIL stall_pre: running=%b, want 1", running1);
            end
         end
      end
      n_cmp++;
      if (done1 !== 1'b1 || reason1 !== 2'b10 || count1 !== 16'd6) begin
         n_err++;
         $display("FAIL stall: done=%b reason=%b count=%0d, want 1 10 6", done1, reason1, count1);
      end
   endtask

   task automatic test_halt_timeout();
      launch();
      for (int n = 1; n <= 10; n++) begin
         pc = 32'(4 * n);
         instr = (n == 10) ? HALT : 32'd0;
         tick();
      end
      instr = 32'd0;
      n_cmp++;
      if (done2 !== 1'b1 || reason2 !== 2'b01 || count2 !== 16'd10) begin
         n_err++;
         $display("FAIL halt_vs_timeout: done=%b reason=%b count=%0d, want 1 01 10", done2, reason2, count2);
      end
   endtask

   task automatic test_abort();
      // abort from DONE clears the reason and keeps the count
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (done2 !== 1'b0 || core_rst2 !== 1'b1 || reason2 !== 2'b00 || count2 !== 16'd10) begin
         n_err++;
         $display("FAIL abort_done: done=%b rst=%b reason=%b count=%0d, want 0 1 00 10", done2, core_rst2, reason2, count2);
      end
      launch();
      for (int n = 1; n <= 5; n++) begin
         pc = 32'(4 * n);
         start = (n == 2 || n == 5) ? 1'b1 : 1'b0;
         abort = (n == 5) ? 1'b1 : 1'b0;
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      n_cmp++;
      if (running1 !== 1'b0 || done1 !== 1'b0 || core_rst1 !== 1'b1 || core_en1 !== 1'b0 ||
          reason1 !== 2'b00 || count1 !== 16'd5) begin
         n_err++;
         $display("FAIL abort_run: run=%b done=%b rst=%b en=%b reason=%b count=%0d, want 0 0 1 0 00 5",
                  running1, done1, core_rst1, core_en1, reason1, count1);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (core_rst1 !== 1'b1 || count1 !== 16'd0 || running1 !== 1'b0) begin
         n_err++;
         $display("FAIL relaunch: rst=%b count=%0d run=%b, want 1 0 0", core_rst1, count1, running1);
      end
      repeat (4) tick();
      n_cmp++;
      if (running1 !== 1'b1) begin
         n_err++;
         $display("FAIL relaunch_run: running=%b, want 1", running1);
      end
   endtask

`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
   task automatic test_trace();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      launch();
      for (int n = 0; n < 10; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      trace_idx = 3'd0;
      #1;
      n_cmp++;
      if (trace_pc1 !== 32'd36) begin
         n_err++;
         $display("FAIL trace_idx0: got %0d, want 36", trace_pc1);
      end
      trace_idx = 3'd7;
      #1;
      n_cmp++;
      if (trace_pc1 !== 32'd8) begin
         n_err++;
         $display("FAIL trace_idx7: got %0d, want 8", trace_pc1);
      end
      trace_idx = 3'd0;
   endtask
`endif

   task automatic test_async_reset();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      launch();
      for (int n = 0; n < 3; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      #3 rst = 1'b0;
      #1;
      n_cmp++;
      if ({core_rst1, core_en1, running1, done1} !== 4'b1000 || reason1 !== 2'b00 || count1 !== 16'd0) begin
         n_err++;
         $display("FAIL async_reset: rst/en/run/done=%b reason=%b count=%0d, want 1000 00 0",
                  {core_rst1, core_en1, running1, done1}, reason1, count1);
      end
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (core_rst1 !== 1'b1 || running1 !== 1'b0) begin
         n_err++;
         $display("FAIL after_async: rst=%b run=%b, want 1 0", core_rst1, running1);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_halt_instr();
      test_stall();
      test_halt_timeout();
      test_abort();
`ifdef MIPS_RUN_CTRL_PC_TRACE_EN
      test_trace();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Synthesizable run/supervision controller for the 32-bit MIPS core.
- Sequences the core's reset and gates its clock enable.
- Counts executed cycles and ends a run on a halt instruction, a PC self-loop, or a cycle timeout.
- Puts on-chip the fixed reset-pulse / fixed-stop-time sequencing that the core bench does by hand, with the reset length, timeout and halt word set by parameters.

Parameters:
- PC_W, 32, width of the core PC input.
- INSTR_W, 32, width of the instruction input.
- CNT_W, 16, width of the cycle counter.
- RST_CYCLES, 4, number of clk cycles core_rst is held high in the RESET state (min 1).
- MAX_CYCLES, 25, run-cycle budget before timeout (1 .. 2^CNT_W-1).
- STALL_LIMIT, 3, consecutive cycles with an unchanged PC that count as a self-loop halt (min 1).
- HALT_INSTR, 32'hFC00_0000, instruction word treated as an explicit halt.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately; release is synchronous to clk.
- start  in  1  single-cycle pulse that begins a run; sampled in IDLE and DONE only.
- abort  in  1  forces the controller to IDLE from any state.
- pc  in  PC_W  current core PC.
- instr  in  INSTR_W  instruction currently being executed by the core.
- core_rst  out  1  active-high reset to the core.
- core_en  out  1  core clock enable.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- halt_reason  out  2  00 none, 01 halt instruction, 10 PC stall, 11 timeout.
- cycle_count  out  CNT_W  number of RUN cycles in the current or last run.

Behaviour:
- States and encoding: IDLE=0, RESET=1, RUN=2, DONE=3.
- Values on rst=0:
  - state=IDLE, core_rst=1, core_en=0, running=0, done=0, halt_reason=00, cycle_count=0.
  - Reset-length counter, stall counter and prev_pc are cleared.
- IDLE:
  - core_rst=1, core_en=0.
  - start=1 -> RESET; cycle_count, halt_reason and the stall counter are cleared.
- RESET:
  - core_rst=1, core_en=0.
  - Stays exactly RST_CYCLES cycles, then -> RUN.
- RUN:
  - core_rst=0, core_en=1, running=1.
  - Every cycle: cycle_count <= cycle_count+1, and pc/instr are evaluated.
  - instr==HALT_INSTR -> DONE, reason 01.
  - The stall counter increments when pc==prev_pc and clears otherwise. The comparison is suppressed on the first RUN cycle, because prev_pc is not yet valid.
  - Stall counter reaching STALL_LIMIT -> DONE, reason 10.
  - Otherwise, cycle_count+1==MAX_CYCLES -> DONE, reason 11.
  - Priority when several conditions hit in the same cycle: 01 > 10 > 11.
  - The terminating cycle is counted, so after a timeout cycle_count==MAX_CYCLES.
- DONE:
  - core_rst=0 and core_en=0, so the core state is frozen for inspection.
  - done=1; halt_reason and cycle_count hold their values.
  - start=1 -> RESET, clearing the counters as from IDLE.
- abort:
  - abort=1 -> IDLE next cycle from any state.
  - Clears halt_reason; cycle_count holds its value.
  - abort has priority over start and over every halt condition in the same cycle.
- start while in RESET or RUN is ignored.
- All outputs are registered. State-derived outputs change on the cycle after the transition edge.
- rst asserted mid-run: every output returns to its reset value immediately, with no wait for the clock edge.

Optional Feature:
- Macro: MIPS_RUN_CTRL_PC_TRACE_EN.
- When defined:
  - An 8-entry ring buffer captures pc on every RUN cycle; the write pointer wraps 7->0.
  - Extra ports: trace_idx (in, 3 bits, 0 = most recent) and trace_pc (out, PC_W bits, combinational read).
  - The buffer and pointer are cleared on rst and on the IDLE/DONE->RESET transition.
  - Unwritten entries read as 0.
- When undefined: no buffer and no extra ports; behaviour is otherwise identical.

Test Plan:
- rst=0 for 3 cycles, then released; start pulse; pc increments by 4 from 0; halt word never appears:
  - core_rst is high for exactly 4 cycles after start, then running=1.
  - DONE after 25 RUN cycles, with halt_reason=11 and cycle_count=25.
- instr=32'hFC00_0000 presented on the 7th RUN cycle -> DONE with halt_reason=01 and cycle_count=7; core_en=0 from the next cycle.
- pc pattern 0,4,8,8,8,8 -> halt_reason=10 after the third repeat of 8, cycle_count=6.
- Halt word and timeout in the same cycle (MAX_CYCLES=10, halt on cycle 10) -> halt_reason=01, cycle_count=10.
- abort asserted on the 5th RUN cycle together with start -> IDLE, core_rst=1, halt_reason=00, cycle_count=5; start the following cycle relaunches RESET.
- Async reset pulse mid-RUN, applied between clock edges -> all outputs reach their reset values before the next rising edge. With MIPS_RUN_CTRL_PC_TRACE_EN, 10 RUN cycles with pc=4n -> trace_idx=0 reads 36, trace_idx=7 reads 8.
